// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: FSM states,
// load/store size codes and the size-to-byte-count helper.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_RD   = 2'd1,
        MC_WR   = 2'd2,
        MC_DONE = 2'd3
    } mc_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Byte count from the size bits; the unused encodings fall into the word case.
    function automatic logic [2:0] access_len(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   access_len = 3'd1;
            2'b01:   access_len = 3'd2;
            default: access_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Sign/zero extension of an assembled little-endian load word, selected by funct3.
module mem_ctrl_load_ext
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    output logic [31:0] ext_o
);

    always_comb begin
        ext_o = raw_i;
        case (funct3_i)
            F3_B:    ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_H:    ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_BU:   ext_o = {24'h000000, raw_i[7:0]};
            F3_HU:   ext_o = {16'h0000, raw_i[15:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: sequences IF fetches and MEM loads/stores
// over an 8-bit RAM port and raises stall requests while a transfer is open.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [2:0]        mem_funct3,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              stallreq_if,
    output logic              stallreq_mem,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [1:0]        dbg_state_o
);

    mc_state_e         state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              is_if_q, is_if_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic [31:0]       ext_word;
    logic [2:0]        cnt_m1;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] issue_a;
    logic [ADDR_W-1:0] prev_a;

    assign cnt_m1  = cnt_q - 3'd1;
    assign lane    = cnt_m1[1:0];
    assign issue_a = base_q + ADDR_W'(cnt_q);
    assign prev_a  = base_q + ADDR_W'(cnt_m1);

    mem_ctrl_load_ext u_load_ext (
        .funct3_i (f3_q),
        .raw_i    (buf_q),
        .ext_o    (ext_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MC_IDLE;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            base_q      <= '0;
            f3_q        <= 3'd0;
            wdata_q     <= ZERO_WORD;
            we_q        <= 1'b0;
            is_if_q     <= 1'b0;
            buf_q       <= ZERO_WORD;
            if_data_q   <= ZERO_WORD;
            mem_rdata_q <= ZERO_WORD;
        end else if (rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            f3_q        <= f3_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            is_if_q     <= is_if_d;
            buf_q       <= buf_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        base_d      = base_q;
        f3_d        = f3_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        is_if_d     = is_if_q;
        buf_d       = buf_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done     = 1'b0;
        mem_done    = 1'b0;
        ram_a       = '0;
        ram_dout    = 8'h00;
        ram_wr      = 1'b0;

        case (state_q)
            MC_IDLE: begin
                cnt_d = 3'd0;
                if (mem_req) begin
                    base_d  = mem_addr;
                    f3_d    = mem_funct3;
                    wdata_d = mem_wdata;
                    len_d   = access_len(mem_funct3);
                    we_d    = mem_we;
                    is_if_d = 1'b0;
                    state_d = mem_we ? MC_WR : MC_RD;
                end else if (if_req) begin
                    base_d  = if_addr;
                    f3_d    = F3_W;
                    len_d   = 3'd4;
                    we_d    = 1'b0;
                    is_if_d = 1'b1;
                    state_d = MC_RD;
                end
            end

            MC_RD: begin
                // While frozen, re-present the previous address so ram_din still
                // carries the byte owed to lane cnt-1 when rdy returns.
                if (!rdy && cnt_q != 3'd0) begin
                    ram_a = prev_a;
                end else if (cnt_q < len_q) begin
                    ram_a = issue_a;
                end
                if (cnt_q != 3'd0) begin
                    buf_d[{lane, 3'b000} +: 8] = ram_din;
                end
                if (cnt_q == len_q) begin
                    state_d = MC_DONE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            MC_WR: begin
                ram_a    = issue_a;
                ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                ram_wr   = rdy;
                if (cnt_q == len_q - 3'd1) begin
                    state_d = MC_DONE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            MC_DONE: begin
                if (is_if_q) begin
                    if_done   = rdy;
                    if_data_d = buf_q;
                end else begin
                    mem_done = rdy;
                    if (!we_q) begin
                        mem_rdata_d = ext_word;
                    end
                end
                state_d = MC_IDLE;
            end

            default: state_d = MC_IDLE;
        endcase
    end

    // Result ports follow the next-state value so data is visible in the done cycle.
    assign if_data      = if_data_d;
    assign mem_rdata    = mem_rdata_d;
    assign stallreq_mem = mem_req & ~mem_done;
    assign stallreq_if  = if_req & ~if_done;
    assign dbg_state_o  = state_q;

endmodule
